// File: rtl/issue_checkpoint_allocator_pkg.sv
// ============================================================================
// Module : issue_cp_pkg
// Desc   : Shared checkpoint-allocator types, sizes and FSM encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package issue_cp_pkg;

    localparam int CP_NUM = 4;
    localparam int CP_W   = 2;

    typedef logic [CP_W-1:0] cp_id_t;
    typedef logic [CP_W:0]   cp_cnt_t;

    typedef enum logic {
        CP_RUN     = 1'b0,
        CP_RECOVER = 1'b1
    } cp_state_t;

endpackage

`default_nettype wire

// File: rtl/issue_checkpoint_allocator_if.sv
// ============================================================================
// Module : issue_checkpoint_allocator_if
// Desc   : DECODE/commit/BCO handshake and checkpoint-array port bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface issue_checkpoint_allocator_if;

    logic                  snoop_hit;
    logic                  alloc_req;
    logic                  alloc_ready;
    issue_cp_pkg::cp_id_t  alloc_id;
    logic                  cp_wea;
    issue_cp_pkg::cp_id_t  cp_addra;
    logic                  commit_valid;
    issue_cp_pkg::cp_id_t  commit_id;
    logic                  cp_wec;
    issue_cp_pkg::cp_id_t  cp_addrc;
    logic                  bco_valid;
    issue_cp_pkg::cp_id_t  bco_id;
    logic                  cp_web;
    issue_cp_pkg::cp_id_t  cp_addrb;
    logic                  recovering;
    issue_cp_pkg::cp_cnt_t cp_count;
    logic                  order_err;

    modport master (
        output snoop_hit, alloc_req, commit_valid, commit_id, bco_valid, bco_id,
        input  alloc_ready, alloc_id, cp_wea, cp_addra, cp_wec, cp_addrc,
               cp_web, cp_addrb, recovering, cp_count, order_err
    );

    modport slave (
        input  snoop_hit, alloc_req, commit_valid, commit_id, bco_valid, bco_id,
        output alloc_ready, alloc_id, cp_wea, cp_addra, cp_wec, cp_addrc,
               cp_web, cp_addrb, recovering, cp_count, order_err
    );

endinterface

`default_nettype wire

// File: rtl/issue_checkpoint_allocator_ptr.sv
// ============================================================================
// Module : issue_cp_ptr
// Desc   : Wrapping checkpoint pointer; load has priority over increment.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module issue_cp_ptr
    import issue_cp_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   resetn,
    input  wire logic   inc,
    input  wire logic   load,
    input  wire cp_id_t load_val,
    output cp_id_t      ptr
);

    cp_id_t r_ptr;

    // CP_NUM is a power of two, so natural overflow gives the wrap.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ptr <= '0;
        end else if (load) begin
            r_ptr <= load_val;
        end else if (inc) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/issue_checkpoint_allocator.sv
// ============================================================================
// Module : issue_checkpoint_allocator
// Desc   : Allocates/frees issue-queue checkpoints in order; flushes on BCO or
//          snoop. ISSUE_CP_ALLOC_COMMIT_BYPASS_EN lets a full queue reuse the
//          slot freed by a same-cycle commit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module issue_checkpoint_allocator
    import issue_cp_pkg::*;
(
    input  wire logic                   clk,
    input  wire logic                   resetn,
    issue_checkpoint_allocator_if.slave bus
);

    cp_state_t r_state;
    cp_state_t w_state_nxt;
    cp_cnt_t   r_count;
    logic      r_order_err;
    cp_id_t    w_head;
    cp_id_t    w_tail;

    logic      w_flush;
    logic      w_bco;
    logic      w_run;
    logic      w_full;
    logic      w_empty;
    logic      w_commit_acc;
    logic      w_alloc_ready;
    logic      w_alloc_acc;
    logic      w_err_set;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= CP_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_flush       = bus.snoop_hit | bus.bco_valid;
        w_bco         = bus.bco_valid & ~bus.snoop_hit;
        w_run         = (r_state == CP_RUN);
        w_full        = (r_count == cp_cnt_t'(CP_NUM));
        w_empty       = (r_count == '0);
        w_commit_acc  = resetn & ~w_flush & w_run & bus.commit_valid & ~w_empty;
`ifdef ISSUE_CP_ALLOC_COMMIT_BYPASS_EN
        w_alloc_ready = resetn & ~w_flush & w_run & (~w_full | w_commit_acc);
`else
        w_alloc_ready = resetn & ~w_flush & w_run & ~w_full;
`endif
        w_alloc_acc   = bus.alloc_req & w_alloc_ready;

        // Protocol violations latch into order_err; the commit itself still
        // proceeds when only its ID is wrong.
        w_err_set = 1'b0;
        if (w_bco) begin
            w_err_set = (bus.bco_id != w_head) | w_empty;
        end else if (!w_flush && bus.commit_valid) begin
            w_err_set = ~w_run | w_empty | (bus.commit_id != w_head);
        end

        w_state_nxt = CP_RUN;
        if (w_flush) begin
            w_state_nxt = CP_RECOVER;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count     <= '0;
            r_order_err <= 1'b0;
        end else begin
            if (w_flush) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + {{CP_W{1'b0}}, w_alloc_acc}
                                   - {{CP_W{1'b0}}, w_commit_acc};
            end
            if (w_err_set) begin
                r_order_err <= 1'b1;
            end
        end
    end

    issue_cp_ptr u_head (
        .clk      (clk),
        .resetn   (resetn),
        .inc      (w_commit_acc),
        .load     (w_flush),
        .load_val (w_tail),
        .ptr      (w_head)
    );

    issue_cp_ptr u_tail (
        .clk      (clk),
        .resetn   (resetn),
        .inc      (w_alloc_acc),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (w_tail)
    );

    assign bus.alloc_ready = w_alloc_ready;
    assign bus.alloc_id    = w_tail;
    assign bus.cp_wea      = w_alloc_acc;
    assign bus.cp_addra    = w_tail;
    assign bus.cp_wec      = w_commit_acc;
    assign bus.cp_addrc    = w_head;
    assign bus.cp_web      = resetn & w_bco;
    assign bus.cp_addrb    = bus.bco_id;
    assign bus.recovering  = resetn & ~w_run;
    assign bus.cp_count    = resetn ? r_count : '0;
    assign bus.order_err   = r_order_err;

endmodule

`default_nettype wire

// File: tb/tb_issue_checkpoint_allocator.sv
// ============================================================================
// Module : tb_issue_checkpoint_allocator
// Desc   : Directed + random stimulus against a queue-based checkpoint model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_issue_checkpoint_allocator;

    logic clk;
    logic resetn;

    issue_checkpoint_allocator_if bus ();

    issue_checkpoint_allocator dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit in_rst;
        int ready;
        int id;
        int wea;
        int addra;
        int wec;
        int addrc;
        int web;
        int addrb;
        int rec;
        int cnt;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the live checkpoints are simply an ordered list of IDs.
    int live[$];
    int next_id = 0;
    bit in_recover = 0;
    bit err_m = 0;
`ifdef ISSUE_CP_ALLOC_COMMIT_BYPASS_EN
    bit bypass = 1;
`else
    bit bypass = 0;
`endif

    function automatic int model_head();
        return (live.size() != 0) ? live[0] : next_id;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input bit rn, input bit sn, input bit bv, input int bid,
                        input bit cv, input int cid, input bit ar);
        exp_t e;
        bit   flush, cacc;
        int   head;
        @(posedge clk);
        #1;
        resetn           = rn;
        bus.snoop_hit    = sn;
        bus.bco_valid    = bv;
        bus.bco_id       = bid[1:0];
        bus.commit_valid = cv;
        bus.commit_id    = cid[1:0];
        bus.alloc_req    = ar;

        head     = model_head();
        e        = '{default: 0};
        e.in_rst = !rn;
        e.addrb  = bid;
        if (!rn) begin
            live.delete();
            next_id    = 0;
            in_recover = 0;
            err_m      = 0;
        end else begin
            flush   = sn || bv;
            cacc    = !flush && !in_recover && cv && live.size() != 0;
            e.ready = (!flush && !in_recover &&
                       (live.size() < 4 || (bypass && cacc))) ? 1 : 0;
            e.id    = next_id;
            e.addra = next_id;
            e.wea   = e.ready & ar;
            e.wec   = cacc;
            e.addrc = head;
            e.web   = bv && !sn;
            e.rec   = in_recover;
            e.cnt   = live.size();
            e.err   = err_m;
            if (flush) begin
                if (e.web && (bid != head || live.size() == 0)) err_m = 1;
                live.delete();
                in_recover = 1;
            end else begin
                if (cv) begin
                    if (in_recover || live.size() == 0 || cid != head) err_m = 1;
                end
                if (cacc) void'(live.pop_front());
                if (e.wea) begin
                    live.push_back(next_id);
                    next_id = (next_id + 1) % 4;
                end
                in_recover = 0;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0, 0);
    endtask

    // Monitor: compares whatever expectation the driver queued for this cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("alloc_ready", 32'(bus.alloc_ready), e.ready);
            chk("cp_wea",      32'(bus.cp_wea),      e.wea);
            chk("cp_wec",      32'(bus.cp_wec),      e.wec);
            chk("cp_web",      32'(bus.cp_web),      e.web);
            chk("recovering",  32'(bus.recovering),  e.rec);
            chk("cp_count",    32'(bus.cp_count),    e.cnt);
            if (!e.in_rst) begin
                chk("alloc_id",  32'(bus.alloc_id),  e.id);
                chk("cp_addra",  32'(bus.cp_addra),  e.addra);
                chk("cp_addrc",  32'(bus.cp_addrc),  e.addrc);
                chk("cp_addrb",  32'(bus.cp_addrb),  e.addrb);
                chk("order_err", 32'(bus.order_err), e.err);
            end
        end
    end

    initial begin
        int h;
        resetn           = 1'b0;
        bus.snoop_hit    = 1'b0;
        bus.bco_valid    = 1'b0;
        bus.bco_id       = '0;
        bus.commit_valid = 1'b0;
        bus.commit_id    = '0;
        bus.alloc_req    = 1'b0;

        // Fill, then one refused request.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 1);
        // Full with same-cycle commit of ID 0 and allocation.
        step(1, 0, 0, 0, 1, 0, 1);
        idle(1);

        // count=2, head=1, then BCO on ID 1 and recovery.
        do_reset();
        step(1, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        step(1, 0, 1, 1, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);

        // Snoop overrides BCO and allocation.
        step(1, 1, 1, 3, 0, 0, 1);
        step(1, 0, 0, 0, 1, 3, 1);
        idle(1);

        // Wrap: allocation paired with in-order commits.
        do_reset();
        step(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1, i % 4, 1);
        step(1, 0, 0, 0, 1, 1, 0);
        idle(1);

        // Commit on empty, wrong-ID commit, sticky error, cleared by reset.
        do_reset();
        step(1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1, 2, 0);
        idle(3);
        do_reset();
        idle(1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bit rn, sn, bv, cv, ar;
            int bid, cid;
            h   = model_head();
            rn  = ($urandom_range(0, 79) != 0);
            sn  = ($urandom_range(0, 24) == 0);
            bv  = ($urandom_range(0, 14) == 0);
            bid = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : h;
            cv  = ($urandom_range(0, 1) == 1);
            cid = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : h;
            ar  = ($urandom_range(0, 3) != 0);
            step(rn, sn, bv, bid, cv, cid, ar);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
